// File: rtl/fp_compare_pipe_if.sv
// rtl/fp_compare_pipe_if.sv - operand/result stream bundle for the float comparator
interface fp_compare_pipe_if #(
  parameter int WE = 8,
  parameter int WF = 11
);
  localparam int W = WE + WF + 3;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic [2:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic         res;
  logic         unordered;
  logic [W-1:0] max_out;
  logic [W-1:0] min_out;

  modport master (
    output in_valid, inA, inB, mode, out_ready,
    input  in_ready, out_valid, res, unordered, max_out, min_out
  );

  modport slave (
    input  in_valid, inA, inB, mode, out_ready,
    output in_ready, out_valid, res, unordered, max_out, min_out
  );
endinterface

// File: rtl/fp_compare_pipe.sv
// rtl/fp_compare_pipe.sv - pipelined FloPoCo float comparator with relation select and min/max
module fp_compare_pipe #(
  parameter int WE     = 8,
  parameter int WF     = 11,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  fp_compare_pipe_if.slave bus
);
  localparam int N  = WE + WF;
  localparam int W  = N + 3;
  localparam int NR = (STAGES >= 2) ? STAGES - 1 : 1;

  // Total order over non-NaN classes; normals of equal rank are split by magnitude.
  localparam logic [2:0] R_NINF  = 3'd0;
  localparam logic [2:0] R_NNORM = 3'd1;
  localparam logic [2:0] R_ZERO  = 3'd2;
  localparam logic [2:0] R_PNORM = 3'd3;
  localparam logic [2:0] R_PINF  = 3'd4;

  typedef struct packed {
    logic         a_nan;
    logic         b_nan;
    logic [2:0]   rank_a;
    logic [2:0]   rank_b;
    logic         mag_lt;
    logic         mag_eq;
    logic [2:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } s1_t;

  typedef struct packed {
    logic         res;
    logic         unordered;
    logic [W-1:0] max_v;
    logic [W-1:0] min_v;
  } res_t;

  function automatic logic [2:0] rank_of(input logic [W-1:0] v);
    case (v[N+2:N+1])
      2'b00:   rank_of = R_ZERO;
      2'b01:   rank_of = v[N] ? R_NNORM : R_PNORM;
      default: rank_of = v[N] ? R_NINF : R_PINF;
    endcase
  endfunction

  logic adv;
  s1_t  s1_d;
  s1_t  s2_in;
  logic v2_in;
  res_t r_d;
  res_t rp_q [NR];
  logic [NR-1:0] vp_q;

  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

  always_comb begin
    s1_d        = '0;
    s1_d.a_nan  = &bus.inA[N+2:N+1];
    s1_d.b_nan  = &bus.inB[N+2:N+1];
    s1_d.rank_a = rank_of(bus.inA);
    s1_d.rank_b = rank_of(bus.inB);
    s1_d.mag_lt = bus.inA[N-1:0] < bus.inB[N-1:0];
    s1_d.mag_eq = bus.inA[N-1:0] == bus.inB[N-1:0];
    s1_d.mode   = bus.mode;
    s1_d.a      = bus.inA;
    s1_d.b      = bus.inB;
  end

  generate
    if (STAGES >= 2) begin : g_split
      s1_t  s1_q;
      logic v1_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_q <= '0;
          v1_q <= 1'b0;
        end else if (adv) begin
          s1_q <= s1_d;
          v1_q <= bus.in_valid;
        end
      end

      assign s2_in = s1_q;
      assign v2_in = v1_q;
    end else begin : g_merged
      assign s2_in = s1_d;
      assign v2_in = bus.in_valid;
    end
  endgenerate

  always_comb begin
    logic lt;
    logic eq;
    logic gt;
    lt  = 1'b0;
    eq  = 1'b0;
    gt  = 1'b0;
    r_d = '0;
    if (!(s2_in.a_nan | s2_in.b_nan)) begin
      if (s2_in.rank_a != s2_in.rank_b) begin
        lt = s2_in.rank_a < s2_in.rank_b;
      end else if (s2_in.rank_a == R_PNORM) begin
        lt = s2_in.mag_lt;
        eq = s2_in.mag_eq;
      end else if (s2_in.rank_a == R_NNORM) begin
        lt = ~s2_in.mag_lt & ~s2_in.mag_eq;
        eq = s2_in.mag_eq;
      end else begin
        eq = 1'b1;
      end
      gt = ~lt & ~eq;
    end

    case (s2_in.mode)
      3'd0:    r_d.res = gt;
      3'd1:    r_d.res = gt | eq;
      3'd2:    r_d.res = lt;
      3'd3:    r_d.res = lt | eq;
      3'd4:    r_d.res = eq;
      3'd5:    r_d.res = ~eq;
      default: r_d.res = 1'b0;
    endcase

    r_d.unordered = s2_in.a_nan | s2_in.b_nan;
    if (s2_in.a_nan) begin
      r_d.max_v = s2_in.a;
      r_d.min_v = s2_in.a;
    end else if (s2_in.b_nan) begin
      r_d.max_v = s2_in.b;
      r_d.min_v = s2_in.b;
    end else begin
      r_d.max_v = lt ? s2_in.b : s2_in.a;
      r_d.min_v = lt ? s2_in.a : s2_in.b;
    end
  end

  // Result register followed by optional pure-delay stages, all frozen together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        rp_q[i] <= '0;
        vp_q[i] <= 1'b0;
      end
    end else if (adv) begin
      rp_q[0] <= r_d;
      vp_q[0] <= v2_in;
      for (int i = 1; i < NR; i++) begin
        rp_q[i] <= rp_q[i-1];
        vp_q[i] <= vp_q[i-1];
      end
    end
  end

  assign bus.out_valid = vp_q[NR-1];
  assign bus.res       = rp_q[NR-1].res;
  assign bus.unordered = rp_q[NR-1].unordered;
  assign bus.max_out   = rp_q[NR-1].max_v;
  assign bus.min_out   = rp_q[NR-1].min_v;

endmodule
